// File: rtl/mul32_seq.sv
// mul32_seq: sequential 32x32 shift-and-add multiplier driving an external 64-bit adder.
// Define MUL_SIGNED_EN to enable two's-complement operands via sgn (magnitude + NEG state).
module mul32_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sgn,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] product,
    output logic        err,
    output logic [63:0] add_a,
    output logic [63:0] add_b,
    output logic        add_cin,
    input  logic [63:0] add_sum,
    input  logic        add_cout
);
`ifdef MUL_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif
    typedef enum logic [1:0] {IDLE, MUL, NEG, DONE} state_t;
    state_t      state_q, state_d;
    logic [63:0] acc_q, acc_d, mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d, mag_a, mag_b;
    logic [4:0]  cnt_q, cnt_d;
    logic        neg_q, neg_d, err_q, err_d;
    assign mag_a     = (SIGNED_EN && sgn && a[31]) ? ~a + 32'd1 : a;
    assign mag_b     = (SIGNED_EN && sgn && b[31]) ? ~b + 32'd1 : b;
    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign product   = acc_q;
    assign err       = err_q;
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        err_d    = err_q;
        add_a    = '0;
        add_b    = '0;
        add_cin  = 1'b0;
        case (state_q)
            IDLE: if (in_valid) begin
                acc_d    = '0;
                mcand_d  = {32'b0, mag_a};
                mplier_d = mag_b;
                cnt_d    = '0;
                err_d    = 1'b0;
                neg_d    = SIGNED_EN & sgn & (a[31] ^ b[31]);
                state_d  = MUL;
            end
            MUL: begin
                add_a = acc_q;
                add_b = mcand_q;
                if (mplier_q[0]) begin
                    acc_d = add_sum;
                    err_d = err_q | add_cout;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = neg_q ? NEG : DONE;
            end
`ifdef MUL_SIGNED_EN
            // Two's-complement negate through the adder: ~acc + 1.
            NEG: begin
                add_a   = ~acc_q;
                add_cin = 1'b1;
                acc_d   = add_sum;
                state_d = DONE;
            end
`endif
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: tb/tb_mul32_seq.sv
// tb_mul32_seq: random and directed checks of mul32_seq against an arithmetic reference model.
module tb_mul32_seq;
`ifdef MUL_SIGNED_EN
    localparam bit SIGNED = 1'b1;
`else
    localparam bit SIGNED = 1'b0;
`endif
    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0, sgn = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        in_ready, out_valid, err, add_cin, add_cout;
    logic [63:0] product, add_a, add_b, add_sum;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {64'b0, add_cin};

    mul32_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sgn(sgn), .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .err(err), .add_a(add_a), .add_b(add_b),
        .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input logic s);
        longint sx, sy;
        longint unsigned ux, uy;
        sx = $signed(x);
        sy = $signed(y);
        ux = {32'b0, x};
        uy = {32'b0, y};
        return (SIGNED && s) ? 64'(sx * sy) : 64'(ux * uy);
    endfunction

    task automatic do_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                         input logic s, input int hold);
        int k, bad, lat;
        logic [63:0] exp, held;
        exp = ref_mul(x, y, s);
        lat = (SIGNED && s && (x[31] ^ y[31])) ? 33 : 32;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 50) begin @(negedge clk); k++; end
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        a = x; b = y; sgn = s; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; a = $urandom; b = $urandom; sgn = $urandom_range(0, 1);
        k = 0; bad = 0;
        while (!out_valid && k < 40) begin
            if (k < 32 && add_cin !== 1'b0) bad++;
            if (k == 32 && add_cin !== 1'b1) bad++;
            @(posedge clk); #1;
            k++;
        end
        check({tag, "_lat"}, 64'(k), 64'(lat));
        check({tag, "_cin"}, 64'(bad), 64'd0);
        check({tag, "_prod"}, product, exp);
        check({tag, "_err"}, 64'(err), 64'd0);
        held = product; bad = 0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (product !== held || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
        end
        if (hold > 0) check({tag, "_stall"}, 64'(bad), 64'd0);
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, "_idle"}, {62'b0, in_ready, out_valid}, 64'd2);
        out_ready = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", {60'b0, in_ready, out_valid, err, add_cin}, 64'h8);
        check("rst_prod", product, 64'd0);
        check("rst_add", add_a | add_b, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        do_op("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
        check("max_const", product, 64'hFFFF_FFFE_0000_0001);
        do_op("zero_b", 32'd12345, 32'd0, 1'b0, 0);
        do_op("neg3x7", 32'hFFFF_FFFD, 32'd7, 1'b1, 0);
        do_op("minxmin", 32'h8000_0000, 32'h8000_0000, 1'b1, 0);
        do_op("stall", 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 10);
        do_op("negzero", 32'hFFFF_FFFF, 32'd0, 1'b1, 0);
        for (int i = 0; i < 20; i++)
            do_op("rand", $urandom, $urandom, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        @(negedge clk);
        a = 32'hFFFF_0001; b = 32'h0F0F_0F0F; sgn = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_flags", {60'b0, in_ready, out_valid, err, add_cin}, 64'h8);
        check("mid_rst_prod", product, 64'd0);
        check("mid_rst_add", add_a | add_b, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        do_op("after_rst", 32'd2, 32'd3, 1'b0, 0);
        check("after_rst_val", product, 64'd6);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mul32_seq.md
# mul32_seq

Sequential 32x32 shift-and-add multiplier that sits directly upstream and downstream of the 64-bit carry-lookahead adder (`Adder64`). It drives the adder's operand and carry-in inputs every cycle and captures its sum back into a 64-bit accumulator. It produces one 64-bit product per transaction over a valid/ready handshake. The adder is purely combinational, so the clock period must exceed the adder's worst-case settle time: 12 gate delays, 15 including overflow.

## Interface
Parameters:
- none; width fixed at 32x32 -> 64.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  operands `a`/`b`/`sgn` valid.
- `in_ready`  out  1  block idle, can accept.
- `a`  in  32  multiplicand.
- `b`  in  32  multiplier.
- `sgn`  in  1  1 = two's-complement operands; used only with `MUL_SIGNED_EN`.
- `out_valid`  out  1  `product` valid; held until accepted.
- `out_ready`  in  1  consumer accepts `product`.
- `product`  out  64  result.
- `err`  out  1  sticky; set if `add_cout`=1 in a MUL cycle; cleared on next accept.
- `add_a`  out  64  to adder `num1`.
- `add_b`  out  64  to adder `num2`.
- `add_cin`  out  1  to adder `c0`.
- `add_sum`  in  64  from adder `sum`.
- `add_cout`  in  1  from adder `C_out`.

## Operation
States:
- IDLE, MUL, NEG, DONE. Encoding is free.

Registers:
- `acc`[63:0], `mcand`[63:0], `mplier`[31:0], `cnt`[4:0], `neg`, `err`.

IDLE:
- `in_ready`=1.
- On `in_valid`:
  - `acc`<=0; `mcand`<={32'b0,|a|}; `mplier`<=|b|; `cnt`<=0; `err`<=0.
  - `neg`<=signed-mode & (a[31]^b[31]).
  - -> MUL.
- |x| is x in unsigned mode; in signed mode it is the 32-bit unsigned magnitude (~x+1 if x[31]). |-2^31| = 0x8000_0000.

MUL (exactly 32 cycles):
- `add_a`=`acc`, `add_b`=`mcand`, `add_cin`=0.
- If `mplier`[0]: `acc`<=`add_sum`.
- If `mplier`[0] & `add_cout`: `err`<=1.
- `mcand`<=`mcand`<<1; `mplier`<=`mplier`>>1; `cnt`<=`cnt`+1.
- When `cnt`==31: -> NEG if `neg`, else DONE.

NEG (1 cycle):
- `add_a`=~`acc`, `add_b`=0, `add_cin`=1.
- `acc`<=`add_sum`; -> DONE.

DONE:
- `out_valid`=1, `product`=`acc`.
- On `out_ready`: -> IDLE.
- `in_ready`=0, so no same-cycle re-accept.

Adder drive and output rules:
- In IDLE and DONE, `add_a`/`add_b`/`add_cin` are all 0.
- `product` is `acc` in every state, but is only meaningful while `out_valid`=1.
- Zero multiplier still takes the full 32 MUL cycles; there is no early exit.
- `in_valid` while busy is ignored; the upstream must hold it until `in_ready`.

## Timing
- Reset (`rst_n`=0 at a rising edge), from any state including mid-MUL:
  - state -> IDLE, all registers 0.
  - `in_ready`=1, `out_valid`=0, `product`=0, `err`=0, `add_*`=0.
  - Any in-flight result is discarded.
- Accept at edge T: first MUL cycle runs T..T+1; last MUL edge is T+32.
- `out_valid` rises after edge T+32 (non-negative result) or T+33 (negated result).
- Throughput: one result per 34 cycles minimum (35 if negated), with `out_ready` held at 1.
- `out_ready` low stalls indefinitely in DONE; `product` stays stable.
- `a`, `b`, `sgn` are sampled only at the accept edge; later changes have no effect.

## Configuration
- `MUL_SIGNED_EN` defined:
  - `sgn`=1 selects the two's-complement path: magnitude conversion plus the NEG state.
  - `sgn`=0 gives an unsigned multiply.
- `MUL_SIGNED_EN` undefined:
  - `sgn` is ignored, `neg` is tied to 0, and the NEG state is not compiled in.
  - All operations are unsigned; latency is always 32.

## Test plan
- Unsigned, a=0xFFFF_FFFF, b=0xFFFF_FFFF -> `product`=0xFFFF_FFFE_0000_0001; `out_valid` after edge T+32; `err`=0.
- a=12345, b=0 -> `product`=0 after the full 32 cycles; `add_cin`=0 throughout MUL.
- `MUL_SIGNED_EN`, `sgn`=1, a=-3 (0xFFFF_FFFD), b=7 -> `product`=0xFFFF_FFFF_FFFF_FFEB (-21); `out_valid` after T+33; NEG cycle drives `add_cin`=1.
- `MUL_SIGNED_EN`, `sgn`=1, a=b=0x8000_0000 -> `product`=0x4000_0000_0000_0000.
- Hold `out_ready`=0 for 10 cycles in DONE -> `product` stable and `in_ready`=0; assert `out_ready` -> IDLE next edge.
- Pull `rst_n` low at MUL cycle 10 -> next edge: `in_ready`=1, `out_valid`=0, `product`=0, `err`=0; a new op a=2, b=3 afterwards yields 6.
